serial_word_comp: RTL and testbench

Parametrised, digit-serial magnitude comparator that compares two words presented `DIGIT_W` bits per cycle over `NUM_DIGITS` digits. Each word is framed by a start/done handshake, and the digit order (MSB-first or LSB-first) and signedness are selected per word. The block sits between serial shift-out datapaths and control logic that needs a registered greater/less/equal verdict per word. It generalises the single-bit, MSB-first, free-running serial comparator.

---
 rtl/serial_word_comp_if.sv | 35 +++
 rtl/serial_word_comp.sv | 120 ++++++++++++
 tb/tb_serial_word_comp.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_comp_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_comp_if
// Purpose  : Digit-serial compare bus: start/mode/digit inputs toward the
//            comparator and busy/done/verdict outputs back to control logic.
// Revision : 1.0  initial release
// ============================================================================
interface serial_word_comp_if #(
  parameter int DIGIT_W = 1
);
  logic               start;
  logic               msb_first;
  logic               is_signed;
  logic               in_valid;
  logic [DIGIT_W-1:0] A;
  logic [DIGIT_W-1:0] B;
  logic               busy;
  logic               done;
  logic               AgtB;
  logic               AltB;
  logic               AeqB;

  // Control side: frames words and supplies digits, consumes the verdict
  modport master (
    output start, msb_first, is_signed, in_valid, A, B,
    input  busy, done, AgtB, AltB, AeqB
  );

  // Comparator side
  modport slave (
    input  start, msb_first, is_signed, in_valid, A, B,
    output busy, done, AgtB, AltB, AeqB
  );
endinterface
`default_nettype wire

// File: rtl/serial_word_comp.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_comp
// Purpose  : Digit-serial magnitude comparator. Compares two words delivered
//            DIGIT_W bits per accepted digit over NUM_DIGITS digits, MSB- or
//            LSB-first, signed or unsigned, and registers a gt/lt/eq verdict.
// Revision : 1.0  initial release
// ============================================================================
module serial_word_comp #(
  parameter int DIGIT_W    = 1,
  parameter int NUM_DIGITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  serial_word_comp_if.slave   bus
);

  localparam int                 c_CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NUM_DIGITS - 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_gt;
  logic               r_lt;
  logic               r_msb;
  logic               r_sgn;
  logic               r_done;
  logic               r_agtb;
  logic               r_altb;
  logic               r_aeqb;

  logic [DIGIT_W-1:0] w_da;
  logic [DIGIT_W-1:0] w_db;
  logic               w_sign_digit;
  logic               w_dgt;
  logic               w_dlt;
  logic               w_gt_nxt;
  logic               w_lt_nxt;

  // Per-digit compare and the running-flag update for the digit on the bus
  always_comb begin
    w_da         = bus.A;
    w_db         = bus.B;
    // The sign digit is the first one sent MSB-first and the last one LSB-first
    w_sign_digit = r_sgn && (r_msb ? (r_cnt == '0) : (r_cnt == c_LAST));
    if (w_sign_digit) begin
      w_dgt = $signed(w_da) > $signed(w_db);
      w_dlt = $signed(w_da) < $signed(w_db);
    end else begin
      w_dgt = w_da > w_db;
      w_dlt = w_da < w_db;
    end
    w_gt_nxt = r_gt;
    w_lt_nxt = r_lt;
    if (r_msb) begin
      // The first differing digit decides; later digits cannot change it
      if (!(r_gt || r_lt)) begin
        w_gt_nxt = w_dgt;
        w_lt_nxt = w_dlt;
      end
    end else begin
      // A differing digit of higher weight overrides anything below it
      if (w_da != w_db) begin
        w_gt_nxt = w_dgt;
        w_lt_nxt = w_dlt;
      end
    end
  end

  // Word sequencing: arm on start, accumulate on valid digits, publish on the last one
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_msb   <= 1'b0;
      r_sgn   <= 1'b0;
      r_done  <= 1'b0;
      r_agtb  <= 1'b0;
      r_altb  <= 1'b0;
      r_aeqb  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      // Start wins in both states: arm from IDLE, or abort-and-rearm in RUN
      if (bus.start) begin
        r_state <= c_RUN;
        r_cnt   <= '0;
        r_gt    <= 1'b0;
        r_lt    <= 1'b0;
        r_msb   <= bus.msb_first;
        r_sgn   <= bus.is_signed;
      end else if (r_state == c_RUN && bus.in_valid) begin
        r_gt <= w_gt_nxt;
        r_lt <= w_lt_nxt;
        if (r_cnt == c_LAST) begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
          r_done  <= 1'b1;
          r_agtb  <= w_gt_nxt;
          r_altb  <= w_lt_nxt;
          r_aeqb  <= ~(w_gt_nxt | w_lt_nxt);
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy = (r_state == c_RUN);
  assign bus.done = r_done;
  assign bus.AgtB = r_agtb;
  assign bus.AltB = r_altb;
  assign bus.AeqB = r_aeqb;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_comp.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_comp
// Purpose  : Directed self-checking bench for serial_word_comp, using a
//            1-bit x 4-digit instance and a 4-bit x 2-digit instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_word_comp;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  serial_word_comp_if #(.DIGIT_W(1)) bus1 ();
  serial_word_comp_if #(.DIGIT_W(4)) bus4 ();

  serial_word_comp #(.DIGIT_W(1), .NUM_DIGITS(4)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  serial_word_comp #(.DIGIT_W(4), .NUM_DIGITS(2)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4.slave)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Absolute run limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // sel 0 -> 1-bit x 4 instance, sel 1 -> 4-bit x 2 instance
  task automatic drive(input int sel, input logic st, input logic msb, input logic sgn,
                       input logic iv, input logic [3:0] a, input logic [3:0] b);
    if (sel == 0) begin
      bus1.start = st; bus1.msb_first = msb; bus1.is_signed = sgn;
      bus1.in_valid = iv; bus1.A = a[0:0]; bus1.B = b[0:0];
    end else begin
      bus4.start = st; bus4.msb_first = msb; bus4.is_signed = sgn;
      bus4.in_valid = iv; bus4.A = a; bus4.B = b;
    end
  endtask

  // {busy, done, AgtB, AltB, AeqB}
  function automatic logic [4:0] status(input int sel);
    if (sel == 0) return {bus1.busy, bus1.done, bus1.AgtB, bus1.AltB, bus1.AeqB};
    return {bus4.busy, bus4.done, bus4.AgtB, bus4.AltB, bus4.AeqB};
  endfunction

  // Extract digit idx of an operand word
  function automatic logic [3:0] digit_of(input int sel, input logic [7:0] w, input int idx);
    logic [7:0] t;
    if (sel == 0) begin
      t = w >> idx;
      return {3'b000, t[0]};
    end
    t = w >> (idx * 4);
    return t[3:0];
  endfunction

  // One full word. Latency counts clock edges from the start edge (=1) to the
  // edge after which done is first seen high. no_gap drives start in the
  // current cycle (e.g. the done cycle of the previous word).
  task automatic run_word(input int sel, input logic msb, input logic sgn,
                          input logic [7:0] aw, input logic [7:0] bw,
                          input int stall_at, input int stall_len, input bit no_gap,
                          input logic [2:0] exp_res, input int exp_lat, input string tag);
    int n;
    int lat;
    int seen;
    int idx;
    logic [4:0] s;
    n = (sel == 0) ? 4 : 2;
    if (!no_gap) begin
      @(posedge clock); #1;
    end
    drive(sel, 1'b1, msb, sgn, 1'b0, 4'h0, 4'h0);
    @(posedge clock); #1;
    lat  = 1;
    seen = 0;
    s = status(sel);
    check({tag, "_busy"}, 32'(s[4]), 32'd1);
    for (int d = 0; d < n; d++) begin
      if (d == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          drive(sel, 1'b0, msb, sgn, 1'b0, 4'hF, 4'h0);
          @(posedge clock); #1;
          lat++;
          if (seen == 0 && status(sel)[3]) seen = lat;
        end
      end
      idx = msb ? (n - 1 - d) : d;
      drive(sel, 1'b0, msb, sgn, 1'b1, digit_of(sel, aw, idx), digit_of(sel, bw, idx));
      @(posedge clock); #1;
      lat++;
      if (seen == 0 && status(sel)[3]) seen = lat;
    end
    drive(sel, 1'b0, msb, sgn, 1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 3 && seen == 0; k++) begin
      @(posedge clock); #1;
      lat++;
      if (status(sel)[3]) seen = lat;
    end
    s = status(sel);
    check({tag, "_lat"}, 32'(seen), 32'(exp_lat));
    check({tag, "_res"}, 32'(s[2:0]), 32'(exp_res));
    check({tag, "_idle"}, 32'(s[4]), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [7:0] ra;
    logic [7:0] rb;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (2) @(posedge clock);
    #1;
    check("reset1", 32'(status(0)), 32'b00001);
    check("reset4", 32'(status(1)), 32'b00001);
    reset = 1'b0;

    // Unsigned MSB-first
    run_word(0, 1'b1, 1'b0, 8'b1011, 8'b1001, -1, 0, 1'b0, 3'b100, 5, "msb_gt");
    @(posedge clock); #1;
    check("done_one_cycle", 32'(status(0)), 32'b00100);
    run_word(0, 1'b1, 1'b0, 8'b1011, 8'b1011, -1, 0, 1'b0, 3'b001, 5, "msb_eq");

    // LSB-first: upper bits dominate
    run_word(0, 1'b0, 1'b0, 8'b0110, 8'b0011, -1, 0, 1'b0, 3'b100, 5, "lsb_gt");
    run_word(0, 1'b0, 1'b0, 8'b0001, 8'b1000, -1, 0, 1'b0, 3'b010, 5, "lsb_lt");

    // Signed vs unsigned, 4-bit digits
    run_word(1, 1'b1, 1'b1, 8'hF0, 8'h10, -1, 0, 1'b0, 3'b010, 3, "sgn_msb");
    run_word(1, 1'b1, 1'b0, 8'hF0, 8'h10, -1, 0, 1'b0, 3'b100, 3, "uns_msb");
    run_word(1, 1'b0, 1'b1, 8'hF0, 8'h10, -1, 0, 1'b0, 3'b010, 3, "sgn_lsb");
    run_word(1, 1'b0, 1'b1, 8'h7F, 8'h80, -1, 0, 1'b0, 3'b100, 3, "sgn_lsb_gt");

    // Three stall cycles between digits 1 and 2
    run_word(0, 1'b1, 1'b0, 8'b1011, 8'b1001, 2, 3, 1'b0, 3'b100, 8, "stall");

    // Back-to-back: second start lands in the done cycle of the first word
    run_word(0, 1'b1, 1'b0, 8'b0011, 8'b0101, -1, 0, 1'b0, 3'b010, 5, "b2b_a");
    run_word(0, 1'b0, 1'b1, 8'b0111, 8'b1000, -1, 0, 1'b1, 3'b100, 5, "b2b_b");

    // Restart after 2 digits; the digit on the restart cycle must be ignored
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    @(posedge clock); #1;
    seen = 0;
    for (int d = 0; d < 2; d++) begin
      drive(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h1);
      @(posedge clock); #1;
      if (status(0)[3]) seen = 1;
    end
    drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 4'h0);
    @(posedge clock); #1;
    if (status(0)[3]) seen = 1;
    check("restart_nodone", 32'(seen), 32'd0);
    check("restart_hold", 32'(status(0)), 32'b10100);
    lat  = 1;
    seen = 0;
    ra   = 8'b0101;
    rb   = 8'b1000;
    for (int d = 0; d < 4; d++) begin
      drive(0, 1'b0, 1'b0, 1'b0, 1'b1, digit_of(0, ra, d), digit_of(0, rb, d));
      @(posedge clock); #1;
      lat++;
      if (seen == 0 && status(0)[3]) seen = lat;
    end
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 3 && seen == 0; k++) begin
      @(posedge clock); #1;
      lat++;
      if (status(0)[3]) seen = lat;
    end
    check("restart_lat", 32'(seen), 32'd5);
    check("restart_res", 32'(status(0)[2:0]), 32'b010);

    // Reset mid-word of a word heading for AgtB
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    @(posedge clock); #1;
    ra = 8'b1100;
    rb = 8'b0100;
    for (int d = 0; d < 2; d++) begin
      drive(0, 1'b0, 1'b1, 1'b0, 1'b1, digit_of(0, ra, 3 - d), digit_of(0, rb, 3 - d));
      @(posedge clock); #1;
    end
    reset = 1'b1;
    drive(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_mid1", 32'(status(0)), 32'b00001);
    check("rst_mid4", 32'(status(1)), 32'b00001);
    seen = 0;
    for (int d = 0; d < 2; d++) begin
      drive(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 4'h0);
      @(posedge clock); #1;
      if (status(0)[3]) seen = 1;
    end
    check("rst_idle_ignore", 32'(seen), 32'd0);
    check("rst_after", 32'(status(0)), 32'b00001);
    run_word(0, 1'b1, 1'b0, 8'b0010, 8'b0011, -1, 0, 1'b0, 3'b010, 5, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
